// File: rtl/mem_map_pkg.sv
// Shared types and default bounds for the memory-map controller.
// Region/state enums plus default parameter constants.
package mem_map_pkg;

  typedef enum logic [1:0] {
    REG_PRAM,
    REG_MAIN,
    REG_IO,
    REG_NONE
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 18;
  localparam int NUM_IO_DEF  = 4;

  localparam logic [15:0] PRAM_BOT_DEF = 16'h0000;
  localparam logic [15:0] PRAM_TOP_DEF = 16'h07FF;
  localparam logic [15:0] MAIN_BOT_DEF = 16'h0800;
  localparam logic [15:0] MAIN_TOP_DEF = 16'h3FFF;
  localparam logic [15:0] IO_BASE_DEF  = 16'h4000;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decoder: addr in, region and I/O index out.
// Priority PRAM > MAIN > IO > NONE; all bounds inclusive.
module mem_region_decode
  import mem_map_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] PRAM_BOT = PRAM_BOT_DEF,
  parameter logic [ADDR_W-1:0] PRAM_TOP = PRAM_TOP_DEF,
  parameter logic [ADDR_W-1:0] MAIN_BOT = MAIN_BOT_DEF,
  parameter logic [ADDR_W-1:0] MAIN_TOP = MAIN_TOP_DEF,
  parameter logic [ADDR_W-1:0] IO_BASE  = IO_BASE_DEF,
  parameter int NUM_IO = NUM_IO_DEF,
  parameter int IDX_W  = 2
) (
  input  logic [ADDR_W-1:0] addr,
  output region_t           region,
  output logic [IDX_W-1:0]  io_idx
);

  // Offset compares wrap below the base, so one
  // unsigned compare covers both bounds.
  logic [ADDR_W-1:0] pram_off;
  logic [ADDR_W-1:0] main_off;
  logic [ADDR_W-1:0] io_off;
  logic pram_hit;
  logic main_hit;
  logic io_hit;

  assign pram_off = addr - PRAM_BOT;
  assign main_off = addr - MAIN_BOT;
  assign io_off   = addr - IO_BASE;

  assign pram_hit = pram_off <= (PRAM_TOP - PRAM_BOT);
  assign main_hit = main_off <= (MAIN_TOP - MAIN_BOT);
  assign io_hit   = io_off < ADDR_W'(NUM_IO);

  assign io_idx = io_off[IDX_W-1:0];

  always_comb begin
    region = REG_NONE;
    priority case (1'b1)
      pram_hit: region = REG_PRAM;
      main_hit: region = REG_MAIN;
      io_hit:   region = REG_IO;
      default:  region = REG_NONE;
    endcase
  end

endmodule

// File: rtl/mem_map_controller.sv
// CPU data/instruction router onto PRAM, main memory and I/O regs.
// Optional MEMCTRL_BUS_ERR_EN adds sticky Bus_Err/Err_Addr.
module mem_map_controller
  import mem_map_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] PRAM_BOT = PRAM_BOT_DEF,
  parameter logic [ADDR_W-1:0] PRAM_TOP = PRAM_TOP_DEF,
  parameter logic [ADDR_W-1:0] MAIN_BOT = MAIN_BOT_DEF,
  parameter logic [ADDR_W-1:0] MAIN_TOP = MAIN_TOP_DEF,
  parameter logic [ADDR_W-1:0] IO_BASE  = IO_BASE_DEF,
  parameter int NUM_IO = NUM_IO_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     CPU_Data_Req,
  input  logic                     CPU_Data_Wr_En,
  input  logic [ADDR_W-1:0]        CPU_Data_Addr,
  input  logic [DATA_W-1:0]        CPU_Data_In,
  output logic [DATA_W-1:0]        CPU_Data_Out,
  output logic                     CPU_Data_Valid,
  output logic                     CPU_Data_Ready,
  input  logic [ADDR_W-1:0]        CPU_Instruction_Addr,
  output logic [INSTR_W-1:0]       CPU_Instruction_Out,
  output logic [ADDR_W-1:0]        Main_Data_Addr,
  output logic [DATA_W-1:0]        Main_Data_Out,
  output logic                     Main_Data_Wr_En,
  input  logic [DATA_W-1:0]        Main_Data_In,
  output logic [ADDR_W-1:0]        Main_Instruction_Addr,
  input  logic [INSTR_W-1:0]       Main_Instruction_In,
  output logic [ADDR_W-1:0]        PRAM_Addr,
  output logic [DATA_W-1:0]        PRAM_Out,
  output logic                     PRAM_Wr_En,
  input  logic [DATA_W-1:0]        PRAM_In,
  input  logic [NUM_IO*DATA_W-1:0] IO_In,
  output logic [NUM_IO*DATA_W-1:0] IO_Out,
  output logic [NUM_IO-1:0]        IO_Wr_Strobe
`ifdef MEMCTRL_BUS_ERR_EN
  ,
  output logic                     Bus_Err,
  output logic [ADDR_W-1:0]        Err_Addr
`endif
);

  localparam int IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

  state_t            state;
  region_t           dec_region;
  logic [IDX_W-1:0]  dec_idx;
  region_t           rd_region;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_mux;
  logic              acc;
  logic              wr_acc;

  logic [DATA_W-1:0] io_q    [NUM_IO];
  logic [DATA_W-1:0] io_in_a [NUM_IO];

  for (genvar g = 0; g < NUM_IO; g++) begin : g_io
    assign io_in_a[g] = IO_In[g*DATA_W +: DATA_W];
    assign IO_Out[g*DATA_W +: DATA_W] = io_q[g];
  end

  mem_region_decode #(
    .ADDR_W   (ADDR_W),
    .PRAM_BOT (PRAM_BOT),
    .PRAM_TOP (PRAM_TOP),
    .MAIN_BOT (MAIN_BOT),
    .MAIN_TOP (MAIN_TOP),
    .IO_BASE  (IO_BASE),
    .NUM_IO   (NUM_IO),
    .IDX_W    (IDX_W)
  ) u_dec (
    .addr   (CPU_Data_Addr),
    .region (dec_region),
    .io_idx (dec_idx)
  );

  assign Main_Instruction_Addr = CPU_Instruction_Addr;
  assign CPU_Instruction_Out   = Main_Instruction_In;

  assign Main_Data_Addr = CPU_Data_Addr;
  assign Main_Data_Out  = CPU_Data_In;
  assign PRAM_Addr      = CPU_Data_Addr;
  assign PRAM_Out       = CPU_Data_In;

  // Ready only in IDLE, so write enables die in WAIT/RESP.
  assign CPU_Data_Ready = (state == ST_IDLE);
  assign acc    = CPU_Data_Req && CPU_Data_Ready;
  assign wr_acc = acc && CPU_Data_Wr_En;

  assign Main_Data_Wr_En = wr_acc && (dec_region == REG_MAIN);
  assign PRAM_Wr_En      = wr_acc && (dec_region == REG_PRAM);

  always_comb begin
    rd_mux = '0;
    unique case (rd_region)
      REG_PRAM: rd_mux = PRAM_In;
      REG_MAIN: rd_mux = Main_Data_In;
      REG_IO:   rd_mux = io_in_a[rd_idx];
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      rd_region      <= REG_NONE;
      rd_idx         <= '0;
      CPU_Data_Out   <= '0;
      CPU_Data_Valid <= 1'b0;
      IO_Wr_Strobe   <= '0;
      for (int i = 0; i < NUM_IO; i++) io_q[i] <= '0;
`ifdef MEMCTRL_BUS_ERR_EN
      Bus_Err  <= 1'b0;
      Err_Addr <= '0;
`endif
    end else begin
      IO_Wr_Strobe   <= '0;
      CPU_Data_Valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (acc) begin
            if (CPU_Data_Wr_En) begin
              if (dec_region == REG_IO) begin
                io_q[dec_idx] <= CPU_Data_In;
                IO_Wr_Strobe  <= NUM_IO'(1) << dec_idx;
              end
            end else begin
              state     <= ST_WAIT;
              rd_region <= dec_region;
              rd_idx    <= dec_idx;
            end
`ifdef MEMCTRL_BUS_ERR_EN
            if (dec_region == REG_NONE && !Bus_Err) begin
              Bus_Err  <= 1'b1;
              Err_Addr <= CPU_Data_Addr;
            end
`endif
          end
        end
        ST_WAIT: begin
          CPU_Data_Out   <= rd_mux;
          CPU_Data_Valid <= 1'b1;
          state          <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_map_controller.sv
// Directed bench for mem_map_controller with read scoreboard.
// Builds with or without MEMCTRL_BUS_ERR_EN.
module tb_mem_map_controller;

  logic        clk;
  logic        reset;
  logic        CPU_Data_Req;
  logic        CPU_Data_Wr_En;
  logic [15:0] CPU_Data_Addr;
  logic [15:0] CPU_Data_In;
  logic [15:0] CPU_Data_Out;
  logic        CPU_Data_Valid;
  logic        CPU_Data_Ready;
  logic [15:0] CPU_Instruction_Addr;
  logic [17:0] CPU_Instruction_Out;
  logic [15:0] Main_Data_Addr;
  logic [15:0] Main_Data_Out;
  logic        Main_Data_Wr_En;
  logic [15:0] Main_Data_In;
  logic [15:0] Main_Instruction_Addr;
  logic [17:0] Main_Instruction_In;
  logic [15:0] PRAM_Addr;
  logic [15:0] PRAM_Out;
  logic        PRAM_Wr_En;
  logic [15:0] PRAM_In;
  logic [63:0] IO_In;
  logic [63:0] IO_Out;
  logic [3:0]  IO_Wr_Strobe;
`ifdef MEMCTRL_BUS_ERR_EN
  logic        Bus_Err;
  logic [15:0] Err_Addr;
`endif

  int passed = 0;
  int total  = 0;
  logic [15:0] q[$];

  mem_map_controller dut (
    .clk                   (clk),
    .reset                 (reset),
    .CPU_Data_Req          (CPU_Data_Req),
    .CPU_Data_Wr_En        (CPU_Data_Wr_En),
    .CPU_Data_Addr         (CPU_Data_Addr),
    .CPU_Data_In           (CPU_Data_In),
    .CPU_Data_Out          (CPU_Data_Out),
    .CPU_Data_Valid        (CPU_Data_Valid),
    .CPU_Data_Ready        (CPU_Data_Ready),
    .CPU_Instruction_Addr  (CPU_Instruction_Addr),
    .CPU_Instruction_Out   (CPU_Instruction_Out),
    .Main_Data_Addr        (Main_Data_Addr),
    .Main_Data_Out         (Main_Data_Out),
    .Main_Data_Wr_En       (Main_Data_Wr_En),
    .Main_Data_In          (Main_Data_In),
    .Main_Instruction_Addr (Main_Instruction_Addr),
    .Main_Instruction_In   (Main_Instruction_In),
    .PRAM_Addr             (PRAM_Addr),
    .PRAM_Out              (PRAM_Out),
    .PRAM_Wr_En            (PRAM_Wr_En),
    .PRAM_In               (PRAM_In),
    .IO_In                 (IO_In),
    .IO_Out                (IO_Out),
    .IO_Wr_Strobe          (IO_Wr_Strobe)
`ifdef MEMCTRL_BUS_ERR_EN
    ,
    .Bus_Err               (Bus_Err),
    .Err_Addr              (Err_Addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every Valid must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && CPU_Data_Valid) begin
      if (q.size() == 0) chk("spurious_valid", 64'(CPU_Data_Valid), 64'd0);
      else chk("rd_data", 64'(CPU_Data_Out), 64'(q.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Read with a hostile write held during WAIT/RESP.
  task automatic rd(input logic [15:0] a, input logic [15:0] exp,
                    input string tag);
    CPU_Data_Req   = 1'b1;
    CPU_Data_Wr_En = 1'b0;
    CPU_Data_Addr  = a;
    q.push_back(exp);
    cyc();
    CPU_Data_Wr_En = 1'b1;
    CPU_Data_In    = 16'hDEAD;
    #1;
    chk({tag, "_wait_valid"}, 64'(CPU_Data_Valid), 64'd0);
    chk({tag, "_wait_ready"}, 64'(CPU_Data_Ready), 64'd0);
    chk({tag, "_wait_wren"}, 64'({Main_Data_Wr_En, PRAM_Wr_En}), 64'd0);
    cyc();
    chk({tag, "_resp_valid"}, 64'(CPU_Data_Valid), 64'd1);
    chk({tag, "_resp_wren"}, 64'({Main_Data_Wr_En, PRAM_Wr_En}), 64'd0);
    cyc();
    CPU_Data_Req   = 1'b0;
    CPU_Data_Wr_En = 1'b0;
    chk({tag, "_idle_valid"}, 64'(CPU_Data_Valid), 64'd0);
    chk({tag, "_idle_ready"}, 64'(CPU_Data_Ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    reset = 1'b1;
    CPU_Data_Req = 1'b0;
    CPU_Data_Wr_En = 1'b0;
    CPU_Data_Addr = '0;
    CPU_Data_In = '0;
    CPU_Instruction_Addr = '0;
    Main_Data_In = '0;
    Main_Instruction_In = '0;
    PRAM_In = '0;
    IO_In = '0;

    cyc();
    cyc();
    chk("rst_out", 64'(CPU_Data_Out), 64'd0);
    chk("rst_valid", 64'(CPU_Data_Valid), 64'd0);
    chk("rst_io", IO_Out, 64'd0);
    chk("rst_strobe", 64'(IO_Wr_Strobe), 64'd0);
`ifdef MEMCTRL_BUS_ERR_EN
    chk("rst_buserr", 64'(Bus_Err), 64'd0);
`endif
    reset = 1'b0;
    cyc();
    chk("rst_ready", 64'(CPU_Data_Ready), 64'd1);

    // PRAM write
    CPU_Data_Req = 1'b1;
    CPU_Data_Wr_En = 1'b1;
    CPU_Data_Addr = 16'h0010;
    CPU_Data_In = 16'hBEEF;
    #1;
    chk("wp_pram_we", 64'(PRAM_Wr_En), 64'd1);
    chk("wp_main_we", 64'(Main_Data_Wr_En), 64'd0);
    chk("wp_pram_addr", 64'(PRAM_Addr), 64'h0010);
    chk("wp_pram_data", 64'(PRAM_Out), 64'hBEEF);
    chk("wp_main_addr", 64'(Main_Data_Addr), 64'h0010);
    cyc();
    CPU_Data_Req = 1'b0;
    chk("wp_ready", 64'(CPU_Data_Ready), 64'd1);
    chk("wp_valid", 64'(CPU_Data_Valid), 64'd0);

    // MAIN write
    CPU_Data_Req = 1'b1;
    CPU_Data_Addr = 16'h0800;
    CPU_Data_In = 16'h7777;
    #1;
    chk("wm_main_we", 64'(Main_Data_Wr_En), 64'd1);
    chk("wm_pram_we", 64'(PRAM_Wr_En), 64'd0);
    chk("wm_main_data", 64'(Main_Data_Out), 64'h7777);
    cyc();
    CPU_Data_Req = 1'b0;
    CPU_Data_Wr_En = 1'b0;

    PRAM_In = 16'hBEEF;
    rd(16'h0010, 16'hBEEF, "rd_pram");

    PRAM_In = 16'h1111;
    Main_Data_In = 16'h2222;
    rd(16'h07FF, 16'h1111, "rd_07ff");
    rd(16'h0800, 16'h2222, "rd_0800");
    rd(16'h3FFF, 16'h2222, "rd_3fff");

`ifdef MEMCTRL_BUS_ERR_EN
    chk("be_before", 64'(Bus_Err), 64'd0);
`endif
    rd(16'h4004, 16'h0000, "rd_unmap");
`ifdef MEMCTRL_BUS_ERR_EN
    chk("be_set", 64'(Bus_Err), 64'd1);
    chk("be_addr", 64'(Err_Addr), 64'h4004);
`endif

    // IO write
    CPU_Data_Req = 1'b1;
    CPU_Data_Wr_En = 1'b1;
    CPU_Data_Addr = 16'h4002;
    CPU_Data_In = 16'h1234;
    #1;
    chk("wio_we", 64'({Main_Data_Wr_En, PRAM_Wr_En}), 64'd0);
    chk("wio_pre_strobe", 64'(IO_Wr_Strobe), 64'd0);
    cyc();
    CPU_Data_Req = 1'b0;
    CPU_Data_Wr_En = 1'b0;
    chk("wio_out", IO_Out, 64'h0000_1234_0000_0000);
    chk("wio_strobe", 64'(IO_Wr_Strobe), 64'b0100);
    cyc();
    chk("wio_strobe_off", 64'(IO_Wr_Strobe), 64'd0);
    chk("wio_hold", IO_Out, 64'h0000_1234_0000_0000);

    IO_In = 64'h0000_0000_00AA_0000;
    rd(16'h4001, 16'h00AA, "rd_io1");

    // Unmapped write: no side effect
    CPU_Data_Req = 1'b1;
    CPU_Data_Wr_En = 1'b1;
    CPU_Data_Addr = 16'h8000;
    CPU_Data_In = 16'h5555;
    #1;
    chk("wun_we", 64'({Main_Data_Wr_En, PRAM_Wr_En}), 64'd0);
    cyc();
    CPU_Data_Req = 1'b0;
    CPU_Data_Wr_En = 1'b0;
    chk("wun_io", IO_Out, 64'h0000_1234_0000_0000);
    chk("wun_strobe", 64'(IO_Wr_Strobe), 64'd0);
    chk("wun_ready", 64'(CPU_Data_Ready), 64'd1);
`ifdef MEMCTRL_BUS_ERR_EN
    chk("be_sticky_addr", 64'(Err_Addr), 64'h4004);
`endif

    // Back-to-back reads with Req held, plus instruction fetch
    PRAM_In = 16'hBEEF;
    CPU_Data_Req = 1'b1;
    CPU_Data_Addr = 16'h0010;
    CPU_Instruction_Addr = 16'h0123;
    Main_Instruction_In = 18'h2ABCD;
    q.push_back(16'hBEEF);
    q.push_back(16'hBEEF);
    #1;
    chk("if_addr", 64'(Main_Instruction_Addr), 64'h0123);
    chk("if_data", 64'(CPU_Instruction_Out), 64'h2ABCD);
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      chk("b2b_ready", 64'(CPU_Data_Ready), 64'((i % 3) == 0));
      chk("b2b_valid", 64'(CPU_Data_Valid), 64'((i % 3) == 2));
      if (CPU_Data_Valid) vcnt++;
      if (i == 1) begin
        Main_Instruction_In = 18'h15555;
        #1;
        chk("if_data_wait", 64'(CPU_Instruction_Out), 64'h15555);
      end
      cyc();
    end
    CPU_Data_Req = 1'b0;
    chk("b2b_vcnt", 64'(vcnt), 64'd2);

    // Reset during WAIT aborts the read
    CPU_Data_Req = 1'b1;
    CPU_Data_Addr = 16'h0010;
    cyc();
    CPU_Data_Req = 1'b0;
    chk("ra_in_wait", 64'(CPU_Data_Ready), 64'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("ra_valid", 64'(CPU_Data_Valid), 64'd0);
    chk("ra_out", 64'(CPU_Data_Out), 64'd0);
    cyc();
    chk("ra_ready", 64'(CPU_Data_Ready), 64'd1);
    chk("ra_valid2", 64'(CPU_Data_Valid), 64'd0);
    chk("ra_io", IO_Out, 64'd0);
    cyc();
    chk("ra_valid3", 64'(CPU_Data_Valid), 64'd0);

    for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
    chk("sb_drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_map_controller.md
MEM_MAP_CONTROLLER -- requirements
Module: mem_map_controller

Interface
REQ-001 SHALL have parameter: DATA_W, 16, data bus width.
REQ-002 SHALL have parameter: ADDR_W, 16, address width.
REQ-003 SHALL have parameter: INSTR_W, 18, instruction width.
REQ-004 SHALL have parameters: PRAM_BOT 0x0000, PRAM_TOP 0x07FF, MAIN_BOT 0x0800, MAIN_TOP 0x3FFF, all inclusive region bounds.
REQ-005 SHALL have parameters: IO_BASE, 0x4000, first I/O register address; NUM_IO, 4, I/O register count (1..16).
REQ-006 SHALL have one clock and synchronous active-high reset: clk  in  1  clock; reset  in  1  synchronous, active-high.
REQ-007 SHALL have CPU ports: CPU_Data_Req in 1; CPU_Data_Wr_En in 1; CPU_Data_Addr in ADDR_W; CPU_Data_In in DATA_W; CPU_Data_Out out DATA_W (registered); CPU_Data_Valid out 1; CPU_Data_Ready out 1; CPU_Instruction_Addr in ADDR_W; CPU_Instruction_Out out INSTR_W.
REQ-008 SHALL have memory ports: Main_Data_Addr/Out out; Main_Data_Wr_En out 1; Main_Data_In in DATA_W; Main_Instruction_Addr out ADDR_W; Main_Instruction_In in INSTR_W; PRAM_Addr/Out out; PRAM_Wr_En out 1; PRAM_In in DATA_W.
REQ-009 SHALL have I/O ports: IO_In in NUM_IO*DATA_W; IO_Out out NUM_IO*DATA_W (registered); IO_Wr_Strobe out NUM_IO.

Function
REQ-010 Instruction path SHALL be combinational passthrough (Main_Instruction_Addr=CPU_Instruction_Addr, CPU_Instruction_Out=Main_Instruction_In), independent of the data FSM.
REQ-011 Decode SHALL be inclusive, in priority order: PRAM, MAIN, IO (IO_BASE..IO_BASE+NUM_IO-1), else UNMAPPED.
REQ-012 Main/PRAM address and write-data outputs SHALL always mirror CPU_Data_Addr/CPU_Data_In.
REQ-013 Request SHALL be accepted only when CPU_Data_Req=1 and CPU_Data_Ready=1; a request with Ready=0 is ignored.
REQ-014 Accepted write SHALL assert exactly one of Main_Data_Wr_En/PRAM_Wr_En for the target in the same cycle, combinationally; no Valid; Ready stays 1.
REQ-015 Accepted IO write SHALL load IO_Out[idx] on that clock edge and pulse IO_Wr_Strobe[idx] for exactly the following cycle.
REQ-016 Write to UNMAPPED SHALL have no side effect.
REQ-017 Read FSM SHALL be IDLE -> WAIT -> RESP -> IDLE; IDLE accepts and registers region/index; WAIT samples source; RESP drives Valid=1 for one cycle.
REQ-018 Read latency SHALL be: Valid asserted in the second cycle after accept; Ready=1 only in IDLE.
REQ-019 Read data in RESP SHALL be PRAM_In, Main_Data_In, IO_In[idx] sampled in WAIT, or 0 for UNMAPPED.
REQ-020 CPU_Data_Out SHALL hold its last value outside RESP.
REQ-021 Wr_En outputs SHALL be 0 in WAIT and RESP.

Reset
REQ-022 Reset SHALL force FSM to IDLE, clear CPU_Data_Out, CPU_Data_Valid, IO_Out, IO_Wr_Strobe to 0; Ready=1 next cycle.
REQ-023 Reset during WAIT/RESP SHALL abort the read with no Valid pulse issued.

Configuration
REQ-024 With MEMCTRL_BUS_ERR_EN defined, SHALL add Bus_Err out 1 (sticky, set on any accepted UNMAPPED access) and Err_Addr out ADDR_W (address of the first such access); both cleared only by reset.
REQ-025 Without MEMCTRL_BUS_ERR_EN, Bus_Err/Err_Addr ports and logic SHALL be absent; UNMAPPED behaviour otherwise identical.

Structure
REQ-026 Package mem_map_pkg SHALL hold the region enum (REG_PRAM, REG_MAIN, REG_IO, REG_NONE), FSM state enum, and default bound constants.
REQ-027 Decode SHALL be the combinational sub-module mem_region_decode (address in; region and IO index out).

Verification
REQ-028 Write 0xBEEF to 0x0010 -> PRAM_Wr_En=1 that cycle, Main_Data_Wr_En=0; read 0x0010 with PRAM_In=0xBEEF -> Valid two cycles later, Data_Out=0xBEEF.
REQ-029 Boundaries: reads at 0x07FF and 0x0800 -> PRAM then MAIN selected; read 0x3FFF -> MAIN; read 0x4004 (NUM_IO=4) -> Data_Out=0, Bus_Err=1, Err_Addr=0x4004 with macro.
REQ-030 Write 0x1234 to 0x4002 -> IO_Out[2]=0x1234, IO_Wr_Strobe=0b0100 for one cycle; IO_In[1]=0x00AA, read 0x4001 -> 0x00AA.
REQ-031 Back-to-back reads with Req held -> second accepted only after Ready returns in IDLE; exactly one Valid per read.
REQ-032 Reset asserted in WAIT -> no Valid, Data_Out=0, Ready=1 the cycle after reset deasserts.
REQ-033 Instruction fetch at 0x0123 concurrent with a data read -> CPU_Instruction_Out equals Main_Instruction_In the same cycle.
